id_ex_stage: RTL and testbench

- Decode-to-execute pipeline stage sitting directly downstream of register_file.
- Takes the two register_file read values and applies operand forwarding from the EX, MEM and WB stages.
- Detects load-use hazards and registers the resolved operands and control into the ID/EX pipeline register.
- Drives the stall back to IF/ID and accepts flush and hold requests.

---
 rtl/id_ex_stage.sv | 165 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM/WB operand forwarding, load-use bubble
// insertion and a running count of inserted bubbles.
module id_ex_stage #(
    parameter int XLEN     = 32,
    parameter int REG_ID_W = 6,
    parameter int CTRL_W   = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                id_valid,
    input  logic [XLEN-1:0]     id_pc,
    input  logic [REG_ID_W-1:0] id_rs1,
    input  logic [REG_ID_W-1:0] id_rs2,
    input  logic [REG_ID_W-1:0] id_rd,
    input  logic [XLEN-1:0]     id_imm,
    input  logic [CTRL_W-1:0]   id_ctrl,
    input  logic                id_is_load,
    input  logic                id_reg_write,
    input  logic [XLEN-1:0]     rf_read1_data,
    input  logic [XLEN-1:0]     rf_read2_data,
    input  logic [XLEN-1:0]     ex_fwd_data,
    input  logic                mem_reg_write,
    input  logic [REG_ID_W-1:0] mem_rd,
    input  logic [XLEN-1:0]     mem_fwd_data,
    input  logic                wb_reg_write,
    input  logic [REG_ID_W-1:0] wb_rd,
    input  logic [XLEN-1:0]     wb_fwd_data,
    input  logic                flush,
    input  logic                ex_hold,
    output logic                stall_out,
    output logic                ex_valid,
    output logic [XLEN-1:0]     ex_pc,
    output logic [XLEN-1:0]     ex_imm,
    output logic [XLEN-1:0]     ex_rs1_val,
    output logic [XLEN-1:0]     ex_rs2_val,
    output logic [REG_ID_W-1:0] ex_rd,
    output logic [CTRL_W-1:0]   ex_ctrl,
    output logic                ex_is_load,
    output logic                ex_reg_write,
    output logic [31:0]         load_use_count
);

    logic                valid_q,     valid_d;
    logic [XLEN-1:0]     pc_q,        pc_d;
    logic [XLEN-1:0]     imm_q,       imm_d;
    logic [XLEN-1:0]     rs1_val_q,   rs1_val_d;
    logic [XLEN-1:0]     rs2_val_q,   rs2_val_d;
    logic [REG_ID_W-1:0] rd_q,        rd_d;
    logic [CTRL_W-1:0]   ctrl_q,      ctrl_d;
    logic                is_load_q,   is_load_d;
    logic                reg_write_q, reg_write_d;
    logic [31:0]         lu_count_q,  lu_count_d;

    logic                load_use;
    logic                ex_can_fwd;
    logic [XLEN-1:0]     rs1_fwd;
    logic [XLEN-1:0]     rs2_fwd;

    // A load in EX has no data yet, so it is never an EX forwarding source.
    function automatic logic [XLEN-1:0] forward(
        input logic [REG_ID_W-1:0] src,
        input logic [XLEN-1:0]     rf_data,
        input logic                ex_ok,
        input logic [REG_ID_W-1:0] ex_dst,
        input logic [XLEN-1:0]     ex_data,
        input logic                mem_we,
        input logic [REG_ID_W-1:0] mem_dst,
        input logic [XLEN-1:0]     mem_data,
        input logic                wb_we,
        input logic [REG_ID_W-1:0] wb_dst,
        input logic [XLEN-1:0]     wb_data
    );
        if (src == '0)                    return '0;
        if (ex_ok  && ex_dst  == src)     return ex_data;
        if (mem_we && mem_dst == src)     return mem_data;
        if (wb_we  && wb_dst  == src)     return wb_data;
        return rf_data;
    endfunction

    assign ex_can_fwd = valid_q && reg_write_q && !is_load_q;

    assign rs1_fwd = forward(id_rs1, rf_read1_data, ex_can_fwd, rd_q, ex_fwd_data,
                             mem_reg_write, mem_rd, mem_fwd_data,
                             wb_reg_write, wb_rd, wb_fwd_data);
    assign rs2_fwd = forward(id_rs2, rf_read2_data, ex_can_fwd, rd_q, ex_fwd_data,
                             mem_reg_write, mem_rd, mem_fwd_data,
                             wb_reg_write, wb_rd, wb_fwd_data);

    assign load_use = id_valid && valid_q && is_load_q && reg_write_q &&
                      (rd_q != '0) && ((rd_q == id_rs1) || (rd_q == id_rs2));

    assign stall_out = load_use || ex_hold;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        valid_d     = valid_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
        rs1_val_d   = rs1_val_q;
        rs2_val_d   = rs2_val_q;
        rd_d        = rd_q;
        ctrl_d      = ctrl_q;
        is_load_d   = is_load_q;
        reg_write_d = reg_write_q;
        lu_count_d  = lu_count_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (ex_hold) begin
            valid_d = valid_q;
        end else if (load_use) begin
            valid_d    = 1'b0;
            lu_count_d = lu_count_q + 32'd1;
        end else begin
            valid_d     = id_valid;
            pc_d        = id_pc;
            imm_d       = id_imm;
            rs1_val_d   = rs1_fwd;
            rs2_val_d   = rs2_fwd;
            rd_d        = id_rd;
            ctrl_d      = id_ctrl;
            is_load_d   = id_is_load;
            reg_write_d = id_reg_write;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!reset_n) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            imm_q       <= '0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            rd_q        <= '0;
            ctrl_q      <= '0;
            is_load_q   <= 1'b0;
            reg_write_q <= 1'b0;
            lu_count_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
            rs1_val_q   <= rs1_val_d;
            rs2_val_q   <= rs2_val_d;
            rd_q        <= rd_d;
            ctrl_q      <= ctrl_d;
            is_load_q   <= is_load_d;
            reg_write_q <= reg_write_d;
            lu_count_q  <= lu_count_d;
        end
    end

    assign ex_valid       = valid_q;
    assign ex_pc          = pc_q;
    assign ex_imm         = imm_q;
    assign ex_rs1_val     = rs1_val_q;
    assign ex_rs2_val     = rs2_val_q;
    assign ex_rd          = rd_q;
    assign ex_ctrl        = ctrl_q;
    assign ex_is_load     = is_load_q;
    assign ex_reg_write   = reg_write_q;
    assign load_use_count = lu_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks of id_ex_stage against a small behavioural
// model of the ID/EX register, forwarding and load-use rules.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [5:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_imm;
    logic [15:0] id_ctrl;
    logic        id_is_load, id_reg_write;
    logic [31:0] rf_read1_data, rf_read2_data, ex_fwd_data;
    logic        mem_reg_write;
    logic [5:0]  mem_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_reg_write;
    logic [5:0]  wb_rd;
    logic [31:0] wb_fwd_data;
    logic        flush, ex_hold;

    logic        stall_out, ex_valid, ex_is_load, ex_reg_write;
    logic [31:0] ex_pc, ex_imm, ex_rs1_val, ex_rs2_val, load_use_count;
    logic [5:0]  ex_rd;
    logic [15:0] ex_ctrl;

    id_ex_stage #(.XLEN(32), .REG_ID_W(6), .CTRL_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .id_is_load(id_is_load), .id_reg_write(id_reg_write),
        .rf_read1_data(rf_read1_data), .rf_read2_data(rf_read2_data),
        .ex_fwd_data(ex_fwd_data),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_fwd_data(mem_fwd_data),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_fwd_data(wb_fwd_data),
        .flush(flush), .ex_hold(ex_hold),
        .stall_out(stall_out), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd),
        .ex_ctrl(ex_ctrl), .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write),
        .load_use_count(load_use_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model of what the EX stage should hold; m_known is low when only valid matters.
    typedef struct {
        logic        valid;
        logic        known;
        logic [31:0] pc, imm, rs1, rs2;
        logic [5:0]  rd;
        logic [15:0] ctrl;
        logic        is_load, rw;
        logic [31:0] cnt;
    } ex_model_t;

    typedef struct {
        logic        hit;
        logic [31:0] data;
    } fwd_src_t;

    ex_model_t m;
    bit        model_init = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd_model(input logic [5:0] src, input logic [31:0] rf);
        fwd_src_t chain [3];
        chain[0].hit  = m.valid && m.rw && !m.is_load && (m.rd == src);
        chain[0].data = ex_fwd_data;
        chain[1].hit  = mem_reg_write && (mem_rd == src);
        chain[1].data = mem_fwd_data;
        chain[2].hit  = wb_reg_write && (wb_rd == src);
        chain[2].data = wb_fwd_data;
        if (src == 6'd0) return 32'd0;
        foreach (chain[i]) if (chain[i].hit) return chain[i].data;
        return rf;
    endfunction

    function automatic logic model_load_use();
        return id_valid && m.valid && m.is_load && m.rw && (m.rd != 6'd0) &&
               ((m.rd == id_rs1) || (m.rd == id_rs2));
    endfunction

    function automatic ex_model_t model_next();
        ex_model_t n = m;
        if (!reset_n) begin
            n = '{valid: 1'b0, known: 1'b1, pc: 0, imm: 0, rs1: 0, rs2: 0,
                  rd: 0, ctrl: 0, is_load: 1'b0, rw: 1'b0, cnt: 0};
        end else if (flush) begin
            n.valid = 1'b0;
            n.known = 1'b0;
        end else if (ex_hold) begin
            n = m;
        end else if (model_load_use()) begin
            n.valid = 1'b0;
            n.known = 1'b0;
            n.cnt   = m.cnt + 32'd1;
        end else begin
            n.valid   = id_valid;
            n.known   = 1'b1;
            n.pc      = id_pc;
            n.imm     = id_imm;
            n.rs1     = fwd_model(id_rs1, rf_read1_data);
            n.rs2     = fwd_model(id_rs2, rf_read2_data);
            n.rd      = id_rd;
            n.ctrl    = id_ctrl;
            n.is_load = id_is_load;
            n.rw      = id_reg_write;
        end
        return n;
    endfunction

    task automatic check_regs();
        check("ex_valid", ex_valid, m.valid);
        check("load_use_count", load_use_count, m.cnt);
        if (m.known) begin
            check("ex_pc", ex_pc, m.pc);
            check("ex_imm", ex_imm, m.imm);
            check("ex_rs1_val", ex_rs1_val, m.rs1);
            check("ex_rs2_val", ex_rs2_val, m.rs2);
            check("ex_rd", ex_rd, m.rd);
            check("ex_ctrl", ex_ctrl, m.ctrl);
            check("ex_is_load", ex_is_load, m.is_load);
            check("ex_reg_write", ex_reg_write, m.rw);
        end
    endtask

    // Inputs are already driven; check the combinational stall, clock once, check registers.
    task automatic step();
        ex_model_t n;
        #2;
        if (model_init) check("stall_out", stall_out, model_load_use() || ex_hold);
        n = model_next();
        if (!reset_n) model_init = 1'b1;
        @(posedge clk);
        m = n;
        #1;
        if (model_init) check_regs();
    endtask

    task automatic idle_inputs();
        reset_n = 1'b1;  id_valid = 1'b0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_imm = 0; id_ctrl = 0; id_is_load = 1'b0; id_reg_write = 1'b0;
        rf_read1_data = 0; rf_read2_data = 0; ex_fwd_data = 0;
        mem_reg_write = 1'b0; mem_rd = 0; mem_fwd_data = 0;
        wb_reg_write = 1'b0; wb_rd = 0; wb_fwd_data = 0;
        flush = 1'b0; ex_hold = 1'b0;
    endtask

    task automatic issue_load(input logic [5:0] rd);
        idle_inputs();
        id_valid = 1'b1; id_pc = 32'h200; id_rd = rd; id_is_load = 1'b1; id_reg_write = 1'b1;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 1000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every input non-zero (hold kept low so stall has a defined answer).
        reset_n = 1'b0; id_valid = 1'b1; id_pc = 32'hDEAD_0004; id_rs1 = 6'd3; id_rs2 = 6'd3;
        id_rd = 6'd9; id_imm = 32'h55; id_ctrl = 16'hFFFF; id_is_load = 1'b1; id_reg_write = 1'b1;
        rf_read1_data = 32'h1; rf_read2_data = 32'h2; ex_fwd_data = 32'h3;
        mem_reg_write = 1'b1; mem_rd = 6'd3; mem_fwd_data = 32'h4;
        wb_reg_write = 1'b1; wb_rd = 6'd3; wb_fwd_data = 32'h5;
        flush = 1'b1; ex_hold = 1'b0;
        step();
        check("reset_stall_out", stall_out, 1'b0);
        check("reset_ex_pc", ex_pc, 32'd0);

        idle_inputs();
        id_valid = 1'b1; id_pc = 32'h100;
        step();
        check("first_ex_pc", ex_pc, 32'h100);
        check("first_ex_valid", ex_valid, 1'b1);

        // Forwarding priority on rs1 = 5.
        idle_inputs();
        id_valid = 1'b1; id_rd = 6'd5; id_reg_write = 1'b1;
        step();
        idle_inputs();
        id_valid = 1'b1; id_rs1 = 6'd5; rf_read1_data = 32'hDDDD; ex_fwd_data = 32'hAAAA;
        mem_reg_write = 1'b1; mem_rd = 6'd5; mem_fwd_data = 32'hBBBB;
        wb_reg_write = 1'b1; wb_rd = 6'd5; wb_fwd_data = 32'hCCCC;
        step();
        check("fwd_ex", ex_rs1_val, 32'hAAAA);
        step();
        check("fwd_mem", ex_rs1_val, 32'hBBBB);
        mem_reg_write = 1'b0;
        step();
        check("fwd_wb", ex_rs1_val, 32'hCCCC);
        wb_reg_write = 1'b0; id_rd = 6'd0; id_reg_write = 1'b1;
        step();
        check("fwd_rf", ex_rs1_val, 32'hDDDD);
        id_rs1 = 6'd0; mem_reg_write = 1'b1; mem_rd = 6'd0; wb_reg_write = 1'b1; wb_rd = 6'd0;
        step();
        check("fwd_x0", ex_rs1_val, 32'd0);

        // Load-use: one bubble, then the load value arrives from MEM.
        issue_load(6'd7);
        idle_inputs();
        id_valid = 1'b1; id_rs2 = 6'd7; rf_read2_data = 32'h9999;
        #1 check("lu_stall", stall_out, 1'b1);
        step();
        check("lu_bubble", ex_valid, 1'b0);
        check("lu_count", load_use_count, 32'd1);
        mem_reg_write = 1'b1; mem_rd = 6'd7; mem_fwd_data = 32'h1234;
        step();
        check("lu_fwd_mem", ex_rs2_val, 32'h1234);
        check("lu_retry_valid", ex_valid, 1'b1);

        // Load to x0 never stalls.
        issue_load(6'd0);
        idle_inputs();
        id_valid = 1'b1; id_rs1 = 6'd0;
        #1 check("x0_no_stall", stall_out, 1'b0);
        step();
        check("x0_count", load_use_count, 32'd1);

        // Hold beats load-use; flush beats hold.
        issue_load(6'd7);
        idle_inputs();
        id_valid = 1'b1; id_rs1 = 6'd7; id_pc = 32'h300; ex_hold = 1'b1;
        step();
        check("hold_pc", ex_pc, 32'h200);
        check("hold_count", load_use_count, 32'd1);
        flush = 1'b1;
        step();
        check("flush_hold_valid", ex_valid, 1'b0);

        // Flush of a valid instruction; reset during a load-use stall.
        idle_inputs();
        id_valid = 1'b1; flush = 1'b1;
        step();
        issue_load(6'd7);
        idle_inputs();
        id_valid = 1'b1; id_rs1 = 6'd7; reset_n = 1'b0;
        step();
        check("rst_lu_valid", ex_valid, 1'b0);
        check("rst_lu_count", load_use_count, 32'd0);
        check("rst_lu_stall", stall_out, 1'b0);

        // Randomized traffic over a small register window so hazards are frequent.
        for (int i = 0; i < 400; i++) begin
            reset_n       = ($urandom_range(0, 63) != 0);
            id_valid      = ($urandom_range(0, 3) != 0);
            id_pc         = $urandom;
            id_rs1        = 6'($urandom_range(0, 7));
            id_rs2        = 6'($urandom_range(0, 7));
            id_rd         = 6'($urandom_range(0, 7));
            id_imm        = $urandom;
            id_ctrl       = 16'($urandom);
            id_is_load    = ($urandom_range(0, 2) == 0);
            id_reg_write  = ($urandom_range(0, 3) != 0);
            rf_read1_data = $urandom;
            rf_read2_data = $urandom;
            ex_fwd_data   = $urandom;
            mem_reg_write = $urandom_range(0, 1);
            mem_rd        = 6'($urandom_range(0, 7));
            mem_fwd_data  = $urandom;
            wb_reg_write  = $urandom_range(0, 1);
            wb_rd         = 6'($urandom_range(0, 7));
            wb_fwd_data   = $urandom;
            flush         = ($urandom_range(0, 15) == 0);
            ex_hold       = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
